mem_stage_pipe_reg: RTL and testbench
=====================================

Name: mem_stage_pipe_reg

Overview:
Parametrised EX->MEM pipeline register for the pipelined CPU. It carries the PC, ALU result, store data, narrowed jump type, register write enable/address, memory write enable and mem-to-reg select. Unlike a free-running register, it has a valid/ready handshake, an optional skid buffer for full throughput under back-pressure, a synchronous flush, and a saturating stall counter. It sits between the execute stage (upstream) and the memory stage (downstream).

Parameters:
PC_W, 5, PC field width
DATA_W, 32, ALU result and write-data width
REG_ADDR_W, 5, destination register address width
JT_IN_W, 4, incoming jump-type width
JT_OUT_W, 3, outgoing jump-type width (must be <= JT_IN_W); the top JT_OUT_W bits are kept
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all held and incoming entries this cycle
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
in_pc  in  PC_W  PC
in_alu_res  in  DATA_W  ALU result / address
in_write_data  in  DATA_W  store data
in_jump_type  in  JT_IN_W  jump type
in_reg_wrenable  in  1  register write enable
in_write_reg  in  REG_ADDR_W  destination register
in_mem_wrenable  in  1  memory write enable
in_mem_to_reg  in  1  writeback select
out_valid  out  1  output entry present
out_ready  in  1  downstream accepts
out_pc, out_alu_res, out_write_data, out_write_reg, out_mem_to_reg  out  as inputs  registered payload
out_jump_type  out  JT_OUT_W  in_jump_type[JT_IN_W-1 -: JT_OUT_W]
out_reg_wrenable  out  1  registered; forced 0 whenever out_valid=0
out_mem_wrenable  out  1  registered; forced 0 whenever out_valid=0
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, all out_* payload=0, skid entry invalid and zeroed, stall_cnt=0. Reset overrides flush and all handshakes, including mid-transfer.
- Accept = in_valid && in_ready. Release = out_valid && out_ready. Latency is 1 cycle from accept to out_valid (empty stage).
- Payload changes only on a load. While out_valid && !out_ready, all out_* hold stable.
- Write enables are stored as (in_x && load). Any cycle that leaves the main entry empty also clears them, so a bubble never writes.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On accept, main <= in and out_valid <= 1.
  - On release without accept, out_valid <= 0.
- SKID=1:
  - in_ready = !skid_valid (registered; 1 after reset).
  - On release with skid_valid: main <= skid and skid_valid <= 0.
  - On accept: if the main entry is empty, or released with no skid entry, main <= in. Otherwise skid <= in and skid_valid <= 1.
  - Sustains 1 entry/cycle. Back-pressure reaches upstream one cycle late, and the skid entry absorbs that cycle.
  - Order is preserved: the skid entry always drains before any newer entry.
- Flush (rst_n=1):
  - Next cycle, out_valid=0, skid_valid=0 and write enables = 0.
  - The incoming entry on the flush cycle is dropped even if in_valid=1.
  - Payload data bits may hold their old values.
  - in_ready is 1 in the cycle after a flush.
- stall_cnt increments when out_valid && !out_ready and saturates at all-ones. It is not cleared by flush.
- Simultaneous accept and release on a full main entry with SKID=0: the new entry replaces the old one with no bubble.

Decomposition:
- Shared package cpu_pipe_pkg:
  - default widths PC_W, DATA_W, REG_ADDR_W.
  - jump-type width constants.
  - a struct for the EX/MEM payload (pc, alu_res, write_data, jump_type, reg_wrenable, write_reg, mem_wrenable, mem_to_reg).
- Natural sub-module: pipe_skid_buf. It is a generic payload-width valid/ready register with a SKID mode and flush. It is instantiated once on the packed payload. Top level adds jump-type narrowing, write-enable gating and stall_cnt.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, stall_cnt=0; in_ready=1 after release.
- Streaming: out_ready=1, inject pc=1..8 back-to-back, alu_res=0xA0+pc, jump_type=4'b1011 -> out_pc 1..8 on consecutive cycles one cycle after input; out_jump_type=3'b101.
- Back-pressure (SKID=1): stream pc=1..4, drop out_ready for 3 cycles after pc=1 appears -> pc=2 lands in skid, in_ready=0 next cycle, no loss or duplication; order 1,2,3,4 preserved; stall_cnt=3.
- Flush: main holds pc=5 with mem_wrenable=1 and skid holds pc=6; assert flush with in_valid=1 for pc=7 -> next cycle out_valid=0, out_mem_wrenable=0, in_ready=1; pc=7 never appears.
- Bubble gating: in_valid=0 with in_reg_wrenable=1 and in_mem_wrenable=1 -> out_reg_wrenable=0 and out_mem_wrenable=0.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default field widths and the EX/MEM payload layout.
package cpu_pipe_pkg;

  localparam int unsigned DEF_PC_W       = 5;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_JT_IN_W    = 4;
  localparam int unsigned DEF_JT_OUT_W   = 3;

  typedef struct packed {
    logic [DEF_PC_W-1:0]       pc;
    logic [DEF_DATA_W-1:0]     alu_res;
    logic [DEF_DATA_W-1:0]     write_data;
    logic [DEF_JT_OUT_W-1:0]   jump_type;
    logic                      reg_wrenable;
    logic [DEF_REG_ADDR_W-1:0] write_reg;
    logic                      mem_wrenable;
    logic                      mem_to_reg;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_pipe_reg_if.sv
// EX->MEM handshake bundle; master is the execute/test side, slave is the pipeline register.
interface mem_stage_pipe_reg_if
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned JT_IN_W    = DEF_JT_IN_W,
  parameter int unsigned JT_OUT_W   = DEF_JT_OUT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [PC_W-1:0]       in_pc;
  logic [DATA_W-1:0]     in_alu_res;
  logic [DATA_W-1:0]     in_write_data;
  logic [JT_IN_W-1:0]    in_jump_type;
  logic                  in_reg_wrenable;
  logic [REG_ADDR_W-1:0] in_write_reg;
  logic                  in_mem_wrenable;
  logic                  in_mem_to_reg;

  logic                  out_valid;
  logic                  out_ready;
  logic [PC_W-1:0]       out_pc;
  logic [DATA_W-1:0]     out_alu_res;
  logic [DATA_W-1:0]     out_write_data;
  logic [JT_OUT_W-1:0]   out_jump_type;
  logic                  out_reg_wrenable;
  logic [REG_ADDR_W-1:0] out_write_reg;
  logic                  out_mem_wrenable;
  logic                  out_mem_to_reg;

  modport master (
    output in_valid, in_pc, in_alu_res, in_write_data, in_jump_type,
           in_reg_wrenable, in_write_reg, in_mem_wrenable, in_mem_to_reg, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_res, out_write_data, out_jump_type,
           out_reg_wrenable, out_write_reg, out_mem_wrenable, out_mem_to_reg
  );

  modport slave (
    input  in_valid, in_pc, in_alu_res, in_write_data, in_jump_type,
           in_reg_wrenable, in_write_reg, in_mem_wrenable, in_mem_to_reg, out_ready,
    output in_ready, out_valid, out_pc, out_alu_res, out_write_data, out_jump_type,
           out_reg_wrenable, out_write_reg, out_mem_wrenable, out_mem_to_reg
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional skid entry and synchronous flush.
// CLR_MASK bits of the main entry are zeroed whenever it is left empty.
module pipe_skid_buf #(
  parameter int unsigned   W        = 8,
  parameter bit            SKID     = 1'b1,
  parameter logic [W-1:0]  CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, rel;

  assign in_ready_o  = SKID ? rdy_q : (!main_v_q || out_ready_i);
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    acc      = in_valid_i && in_ready_o;
    rel      = main_v_q && out_ready_i;

    // A held skid entry always refills main before any newer entry.
    if (rel) begin
      if (SKID && skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
    end

    if (acc) begin
      if (!SKID || !main_v_q || (rel && !skid_v_q)) begin
        main_d   = in_data_i;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_data_i;
        skid_v_d = 1'b1;
      end
    end

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end

    if (!main_v_d) begin
      main_d = main_d & ~CLR_MASK;
    end

    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/mem_stage_pipe_reg.sv
// EX->MEM pipeline register: narrows jump type, keeps write enables off for bubbles,
// and counts back-pressured cycles with a saturating counter.
module mem_stage_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned JT_IN_W    = DEF_JT_IN_W,
  parameter int unsigned JT_OUT_W   = DEF_JT_OUT_W,
  parameter bit          SKID       = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mem_stage_pipe_reg_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     write_data;
    logic [JT_OUT_W-1:0]   jump_type;
    logic                  reg_wrenable;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  mem_wrenable;
    logic                  mem_to_reg;
  } payload_t;

  localparam int unsigned PL_W = $bits(payload_t);
  localparam payload_t WE_MASK = '{reg_wrenable: 1'b1, mem_wrenable: 1'b1, default: '0};

  payload_t in_pl, out_pl;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    in_pl              = '0;
    in_pl.pc           = bus.in_pc;
    in_pl.alu_res      = bus.in_alu_res;
    in_pl.write_data   = bus.in_write_data;
    in_pl.jump_type    = bus.in_jump_type[JT_IN_W-1 -: JT_OUT_W];
    in_pl.reg_wrenable = bus.in_reg_wrenable;
    in_pl.write_reg    = bus.in_write_reg;
    in_pl.mem_wrenable = bus.in_mem_wrenable;
    in_pl.mem_to_reg   = bus.in_mem_to_reg;
  end

  pipe_skid_buf #(
    .W        (PL_W),
    .SKID     (SKID),
    .CLR_MASK (WE_MASK)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_pl)
  );

  assign bus.out_pc           = out_pl.pc;
  assign bus.out_alu_res      = out_pl.alu_res;
  assign bus.out_write_data   = out_pl.write_data;
  assign bus.out_jump_type    = out_pl.jump_type;
  assign bus.out_reg_wrenable = out_pl.reg_wrenable;
  assign bus.out_write_reg    = out_pl.write_reg;
  assign bus.out_mem_wrenable = out_pl.mem_wrenable;
  assign bus.out_mem_to_reg   = out_pl.mem_to_reg;

  // Saturating back-pressure counter; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_stage_pipe_reg.sv
// Directed bench: skid-mode instance for streaming/back-pressure/flush, and a
// non-skid 4-bit-counter instance for same-cycle replace and counter saturation.
module tb_mem_stage_pipe_reg;

  logic clk;
  logic rst_n;
  logic flush1, flush2;
  logic [15:0] stall1;
  logic [3:0]  stall2;

  int n_checks = 0;
  int n_err    = 0;

  mem_stage_pipe_reg_if bus ();
  mem_stage_pipe_reg_if bus2 ();

  mem_stage_pipe_reg #(.SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(bus), .stall_cnt(stall1)
  );

  mem_stage_pipe_reg #(.SKID(1'b0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2), .stall_cnt(stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] pc, input logic mwe);
    bus.in_valid        = v;
    bus.in_pc           = pc;
    bus.in_alu_res      = 32'h0000_00A0 + 32'(pc);
    bus.in_write_data   = 32'h1234_0000 + 32'(pc);
    bus.in_jump_type    = 4'b1011;
    bus.in_reg_wrenable = 1'b1;
    bus.in_write_reg    = pc;
    bus.in_mem_wrenable = mwe;
    bus.in_mem_to_reg   = pc[0];
  endtask

  task automatic drive2(input logic v, input logic [4:0] pc);
    bus2.in_valid        = v;
    bus2.in_pc           = pc;
    bus2.in_alu_res      = 32'h0000_00A0 + 32'(pc);
    bus2.in_write_data   = 32'h0;
    bus2.in_jump_type    = 4'b0110;
    bus2.in_reg_wrenable = 1'b1;
    bus2.in_write_reg    = pc;
    bus2.in_mem_wrenable = 1'b1;
    bus2.in_mem_to_reg   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush1 = 1'b0;
    flush2 = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;
    drive(1'b1, 5'd9, 1'b1);
    drive2(1'b1, 5'd9);

    // Reset with valid input present
    tick();
    tick();
    check("rst_valid",  64'(bus.out_valid), 64'd0);
    check("rst_pc",     64'(bus.out_pc), 64'd0);
    check("rst_alu",    64'(bus.out_alu_res), 64'd0);
    check("rst_mwe",    64'(bus.out_mem_wrenable), 64'd0);
    check("rst_rwe",    64'(bus.out_reg_wrenable), 64'd0);
    check("rst_stall",  64'(stall1), 64'd0);
    check("rst_valid2", 64'(bus2.out_valid), 64'd0);
    check("rst_stall2", 64'(stall2), 64'd0);
    drive(1'b0, 5'd0, 1'b0);
    drive2(1'b0, 5'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_in_ready2", 64'(bus2.in_ready), 64'd1);

    // Streaming pc=1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 1'b0);
      tick();
      check("str_valid", 64'(bus.out_valid), 64'd1);
      check("str_pc",    64'(bus.out_pc), 64'(i));
      check("str_alu",   64'(bus.out_alu_res), 64'(32'hA0 + i));
      check("str_jt",    64'(bus.out_jump_type), 64'b101);
      check("str_ready", 64'(bus.in_ready), 64'd1);
    end

    // Bubble gating: write enables requested but no valid input
    drive(1'b0, 5'd10, 1'b1);
    tick();
    check("bub_valid", 64'(bus.out_valid), 64'd0);
    check("bub_rwe",   64'(bus.out_reg_wrenable), 64'd0);
    check("bub_mwe",   64'(bus.out_mem_wrenable), 64'd0);

    // Back-pressure through the skid entry
    drive(1'b1, 5'd1, 1'b0);
    tick();
    check("bp_pc1", 64'(bus.out_pc), 64'd1);
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd2, 1'b0);
    tick();
    check("bp_hold1_pc", 64'(bus.out_pc), 64'd1);
    check("bp_in_ready0", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 5'd3, 1'b0);
    tick();
    check("bp_hold2_pc", 64'(bus.out_pc), 64'd1);
    tick();
    check("bp_hold3_pc", 64'(bus.out_pc), 64'd1);
    check("bp_stall3", 64'(stall1), 64'd3);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pc2", 64'(bus.out_pc), 64'd2);
    check("bp_valid2", 64'(bus.out_valid), 64'd1);
    check("bp_in_ready1", 64'(bus.in_ready), 64'd1);
    tick();
    check("bp_pc3", 64'(bus.out_pc), 64'd3);
    drive(1'b1, 5'd4, 1'b0);
    tick();
    check("bp_pc4", 64'(bus.out_pc), 64'd4);
    drive(1'b0, 5'd0, 1'b0);
    tick();
    check("bp_drained", 64'(bus.out_valid), 64'd0);
    check("bp_stall_final", 64'(stall1), 64'd3);

    // Flush with main=5 (mem write) and skid=6 held, pc=7 offered
    drive(1'b1, 5'd5, 1'b1);
    tick();
    check("fl_pc5", 64'(bus.out_pc), 64'd5);
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd6, 1'b0);
    tick();
    check("fl_mwe_before", 64'(bus.out_mem_wrenable), 64'd1);
    check("fl_stall4", 64'(stall1), 64'd4);
    flush1 = 1'b1;
    drive(1'b1, 5'd7, 1'b1);
    tick();
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_mwe",   64'(bus.out_mem_wrenable), 64'd0);
    check("fl_rwe",   64'(bus.out_reg_wrenable), 64'd0);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    flush1 = 1'b0;
    drive(1'b0, 5'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("fl_after1", 64'(bus.out_valid), 64'd0);
    tick();
    check("fl_after2", 64'(bus.out_valid), 64'd0);
    check("fl_stall_kept", 64'(stall1), 64'd5);

    // Non-skid instance: same-cycle replace, comb in_ready, saturation
    drive2(1'b1, 5'd1);
    tick();
    check("ns_pc1", 64'(bus2.out_pc), 64'd1);
    check("ns_ready_full", 64'(bus2.in_ready), 64'd1);
    drive2(1'b1, 5'd2);
    tick();
    check("ns_pc2", 64'(bus2.out_pc), 64'd2);
    check("ns_valid2", 64'(bus2.out_valid), 64'd1);
    check("ns_jt", 64'(bus2.out_jump_type), 64'b011);
    drive2(1'b0, 5'd0);
    bus2.out_ready = 1'b0;
    #1;
    check("ns_ready_comb0", 64'(bus2.in_ready), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt10", 64'(stall2), 64'd10);
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt15", 64'(stall2), 64'd15);
    check("sat_pc_hold", 64'(bus2.out_pc), 64'd2);
    check("sat_mwe_hold", 64'(bus2.out_mem_wrenable), 64'd1);

    // Flush drops an accepted-looking input on the non-skid instance
    flush2 = 1'b1;
    bus2.out_ready = 1'b1;
    drive2(1'b1, 5'd3);
    tick();
    check("ns_fl_valid", 64'(bus2.out_valid), 64'd0);
    check("ns_fl_mwe", 64'(bus2.out_mem_wrenable), 64'd0);
    flush2 = 1'b0;
    drive2(1'b0, 5'd0);
    tick();
    check("ns_fl_after", 64'(bus2.out_valid), 64'd0);
    check("ns_stall_kept", 64'(stall2), 64'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
